gate_sweep_checker: RTL and testbench

Synthesisable, parametrised exhaustive truth-table checker for N-input combinational cells, such as NAND3_X2. It drives every input pattern onto a cell under test, waits a configurable settle time, and samples the cell output. The sample is compared against a truth-table parameter, with mismatches counted and the first failing pattern recorded. It sits beside a cell instance in the cell-library benches, replacing hand-written per-pattern stimulus and display sequences.

---
 rtl/gate_sweep_pkg.sv | 31 +++
 rtl/sweep_settle_ctr.sv | 40 ++++
 rtl/gate_sweep_checker.sv | 155 +++++++++++++++
 tb/tb_gate_sweep_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
// Shared definitions for the exhaustive gate truth-table checker.
//   sweep_state_e   : sweep controller states (IDLE, HOLD, DONE)
//   *_TT            : truth tables for common cells; bit k is the output
//                     expected when the input pattern equals k
//                     (pattern MSB drives A1)
//   err_cnt_width() : width of the mismatch counter for an N-input cell
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  localparam logic [3:0]  NAND2_TT = 4'h7;
  localparam logic [7:0]  NAND3_TT = 8'h7F;
  localparam logic [15:0] NAND4_TT = 16'h7FFF;
  localparam logic [3:0]  NOR2_TT  = 4'h1;
  localparam logic [7:0]  NOR3_TT  = 8'h01;
  localparam logic [7:0]  AND3_TT  = 8'h80;
  localparam logic [7:0]  OR3_TT   = 8'hFE;
  localparam logic [3:0]  XOR2_TT  = 4'h6;

  // The counter must reach 2**n_in (every pattern failing), which needs
  // one bit more than the pattern index.
  function automatic int err_cnt_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/sweep_settle_ctr.sv
// sweep_settle_ctr
// Loadable down-counter that times how long each pattern is held on the
// cell before its output is sampled.
//   CK       : clock, rising edge
//   RN       : asynchronous active-low reset
//   i_load   : load the counter with SETTLE (takes priority over counting)
//   i_en     : count down while high
//   o_expire : combinational pulse on the edge where the hold time ends
module sweep_settle_ctr #(
  parameter int SETTLE = 2
) (
  input  logic CK,
  input  logic RN,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int            W        = $clog2(SETTLE + 1);
  localparam logic [W-1:0]  LOAD_VAL = W'(SETTLE);
  localparam logic [W-1:0]  ONE      = W'(1);

  logic [W-1:0] r_count;

  // Expiry is flagged while the count still reads one, so a load of
  // SETTLE at edge e gives an expiry exactly on edge e+SETTLE.
  assign o_expire = i_en && (r_count == ONE);

  // Load wins over counting; the count parks at zero once it runs out.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Exhaustive truth-table checker for an N_IN-input combinational cell.
// Every input pattern is driven in ascending order, held for SETTLE
// cycles, and the cell output is compared against EXPECT.
//   CK               : clock, rising edge
//   RN               : asynchronous active-low reset
//   start            : request a sweep (honoured in IDLE or DONE only)
//   stim             : pattern to the cell, MSB drives A1
//   dut_zn           : cell output
//   busy             : sweep in progress
//   done             : sweep finished, held until next start or reset
//   pass             : valid with done, high when no mismatch was seen
//   err_cnt          : mismatch count, saturating at 2**N_IN
//   first_fail_idx   : pattern index of the first mismatch
//   first_fail_valid : first_fail_idx holds a recorded index
// Optional macro GATE_SWEEP_LOG_EN adds simulation-only logging of each
// compare and a summary at the end of the sweep.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int                  N_IN         = 3,
  parameter logic [2**N_IN-1:0]  EXPECT       = NAND3_TT,
  parameter int                  SETTLE       = 2,
  parameter int                  STOP_ON_FAIL = 0
) (
  input  logic                            CK,
  input  logic                            RN,
  input  logic                            start,
  output logic [N_IN-1:0]                 stim,
  input  logic                            dut_zn,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [err_cnt_width(N_IN)-1:0]  err_cnt,
  output logic [N_IN-1:0]                 first_fail_idx,
  output logic                            first_fail_valid
);

  localparam int            EW      = err_cnt_width(N_IN);
  localparam logic [EW-1:0] ERR_MAX = EW'(2**N_IN);
  localparam logic [EW-1:0] ERR_ONE = EW'(1);
  localparam logic          STOP_EN = (STOP_ON_FAIL != 0);

  sweep_state_e    r_state;
  logic [N_IN-1:0] r_stim;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [EW-1:0]   r_err_cnt;
  logic [N_IN-1:0] r_ff_idx;
  logic            r_ff_valid;

  logic w_accept;
  logic w_expire;
  logic w_mismatch;
  logic w_last;
  logic w_stop;
  logic w_load;
  logic w_hold;

  assign w_hold     = (r_state == HOLD);
  assign w_accept   = start && !w_hold;
  // Four-state compare so an X or Z from the cell counts as a failure.
  assign w_mismatch = (dut_zn !== EXPECT[r_stim]);
  assign w_last     = &r_stim;
  assign w_stop     = w_last || (STOP_EN && w_mismatch);
  assign w_load     = w_accept || (w_hold && w_expire && !w_stop);

  sweep_settle_ctr #(
    .SETTLE (SETTLE)
  ) u_settle (
    .CK       (CK),
    .RN       (RN),
    .i_load   (w_load),
    .i_en     (w_hold),
    .o_expire (w_expire)
  );

  // Sweep controller. Results are only written on compare edges, so they
  // stay frozen from the done edge until the next accepted start.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= IDLE;
      r_stim     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_ff_idx   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= HOLD;
            r_stim     <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_ff_idx   <= '0;
            r_ff_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (w_expire) begin
            if (w_mismatch) begin
              if (r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + ERR_ONE;
              end
              if (!r_ff_valid) begin
                r_ff_idx   <= r_stim;
                r_ff_valid <= 1'b1;
              end
            end
            if (w_stop) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_cnt == '0) && !w_mismatch;
            end else begin
              r_stim <= r_stim + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stim             = r_stim;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_cnt          = r_err_cnt;
  assign first_fail_idx   = r_ff_idx;
  assign first_fail_valid = r_ff_valid;

`ifdef GATE_SWEEP_LOG_EN
  // Per-compare trace plus a one-line verdict when the sweep ends.
  always @(posedge CK) begin
    if (RN && w_hold && w_expire) begin
      $display("%b: %b%s", r_stim, dut_zn, w_mismatch ? " MISMATCH" : "");
      if (w_stop) begin
        $display("gate sweep errors=%0d %s",
                 int'(r_err_cnt) + (w_mismatch ? 1 : 0),
                 ((r_err_cnt == '0) && !w_mismatch) ? "PASS" : "FAIL");
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
// Drives three checker instances (NAND3 default, NAND3 stop-on-fail,
// NAND4 with single-cycle settle) against modelled cell responses and
// compares their outputs with expectations derived from the sweep rules.
module tb_gate_sweep_checker;
  import gate_sweep_pkg::*;

  localparam int F_STIM = 0;
  localparam int F_BUSY = 1;
  localparam int F_DONE = 2;
  localparam int F_PASS = 3;
  localparam int F_ERR  = 4;
  localparam int F_FFI  = 5;
  localparam int F_FFV  = 6;

  logic        CK = 1'b0;
  logic        RN;
  logic [2:0]  startVec;
  logic [7:0]  respA, respB;
  logic [15:0] respC;

  logic [2:0] stimA, stimB;
  logic [3:0] stimC;
  logic       znA, znB, znC;
  logic       busyA, busyB, busyC;
  logic       doneA, doneB, doneC;
  logic       passA, passB, passC;
  logic [3:0] errA, errB;
  logic [4:0] errC;
  logic [2:0] ffiA, ffiB;
  logic [3:0] ffiC;
  logic       ffvA, ffvB, ffvC;

  int checkCount = 0;
  int passCount  = 0;

  always #5 CK = ~CK;

  // Behavioural cells: the response table is indexed by the applied pattern.
  assign znA = respA[stimA];
  assign znB = respB[stimB];
  assign znC = respC[stimC];

  gate_sweep_checker #(.N_IN(3), .EXPECT(NAND3_TT), .SETTLE(2), .STOP_ON_FAIL(0)) uA (
    .CK(CK), .RN(RN), .start(startVec[0]), .stim(stimA), .dut_zn(znA),
    .busy(busyA), .done(doneA), .pass(passA), .err_cnt(errA),
    .first_fail_idx(ffiA), .first_fail_valid(ffvA));

  gate_sweep_checker #(.N_IN(3), .EXPECT(NAND3_TT), .SETTLE(2), .STOP_ON_FAIL(1)) uB (
    .CK(CK), .RN(RN), .start(startVec[1]), .stim(stimB), .dut_zn(znB),
    .busy(busyB), .done(doneB), .pass(passB), .err_cnt(errB),
    .first_fail_idx(ffiB), .first_fail_valid(ffvB));

  gate_sweep_checker #(.N_IN(4), .EXPECT(NAND4_TT), .SETTLE(1), .STOP_ON_FAIL(0)) uC (
    .CK(CK), .RN(RN), .start(startVec[2]), .stim(stimC), .dut_zn(znC),
    .busy(busyC), .done(doneC), .pass(passC), .err_cnt(errC),
    .first_fail_idx(ffiC), .first_fail_valid(ffvC));

  function automatic logic [31:0] obsOf(input int inst, input int field);
    logic [31:0] v;
    v = '0;
    case (inst)
      0: case (field)
           F_STIM: v = 32'(stimA);
           F_BUSY: v = 32'(busyA);
           F_DONE: v = 32'(doneA);
           F_PASS: v = 32'(passA);
           F_ERR:  v = 32'(errA);
           F_FFI:  v = 32'(ffiA);
           default: v = 32'(ffvA);
         endcase
      1: case (field)
           F_STIM: v = 32'(stimB);
           F_BUSY: v = 32'(busyB);
           F_DONE: v = 32'(doneB);
           F_PASS: v = 32'(passB);
           F_ERR:  v = 32'(errB);
           F_FFI:  v = 32'(ffiB);
           default: v = 32'(ffvB);
         endcase
      default: case (field)
           F_STIM: v = 32'(stimC);
           F_BUSY: v = 32'(busyC);
           F_DONE: v = 32'(doneC);
           F_PASS: v = 32'(passC);
           F_ERR:  v = 32'(errC);
           F_FFI:  v = 32'(ffiC);
           default: v = 32'(ffvC);
         endcase
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic checkAllReset(input int inst, input string tag);
    checkOutput({tag, " stim"}, obsOf(inst, F_STIM), 0);
    checkOutput({tag, " busy"}, obsOf(inst, F_BUSY), 0);
    checkOutput({tag, " done"}, obsOf(inst, F_DONE), 0);
    checkOutput({tag, " pass"}, obsOf(inst, F_PASS), 0);
    checkOutput({tag, " err"},  obsOf(inst, F_ERR),  0);
    checkOutput({tag, " ffi"},  obsOf(inst, F_FFI),  0);
    checkOutput({tag, " ffv"},  obsOf(inst, F_FFV),  0);
  endtask

  task automatic setResp(input int inst, input logic [15:0] resp);
    case (inst)
      0: respA = resp[7:0];
      1: respB = resp[7:0];
      default: respC = resp;
    endcase
  endtask

  // Starts a sweep: start is raised before edge e0 and (unless held)
  // dropped half a cycle after it, leaving the bench just after e0.
  task automatic applyStimulus(input int inst, input bit holdStart);
    @(negedge CK);
    startVec[inst] = 1'b1;
    @(negedge CK);
    if (!holdStart) startVec[inst] = 1'b0;
  endtask

  // Called half a cycle after e0. The reference expects a NAND cell:
  // output low only for the all-ones pattern.
  task automatic followSweep(input int inst, input string tag, input logic [15:0] resp);
    int nPat;
    int settle;
    bit stopOnFail;
    int expErr;
    int expFirst;
    int stopK;
    bit seenFail;
    bit want;
    nPat       = (inst == 2) ? 16 : 8;
    settle     = (inst == 2) ? 1 : 2;
    stopOnFail = (inst == 1);
    expErr     = 0;
    expFirst   = 0;
    stopK      = nPat - 1;
    seenFail   = 1'b0;
    for (int k = 0; k < nPat; k++) begin
      want = (k != nPat - 1);
      if (resp[k] !== want) begin
        expErr++;
        if (!seenFail) begin
          seenFail = 1'b1;
          expFirst = k;
        end
        if (stopOnFail) begin
          stopK = k;
          break;
        end
      end
    end
    for (int t = 0; t < (stopK + 1) * settle; t++) begin
      checkOutput($sformatf("%s stim t=%0d", tag, t), obsOf(inst, F_STIM), 32'(t / settle));
      checkOutput($sformatf("%s done t=%0d", tag, t), obsOf(inst, F_DONE), 0);
      @(negedge CK);
    end
    checkOutput({tag, " done"}, obsOf(inst, F_DONE), 1);
    checkOutput({tag, " busy"}, obsOf(inst, F_BUSY), 0);
    checkOutput({tag, " pass"}, obsOf(inst, F_PASS), (expErr == 0) ? 1 : 0);
    checkOutput({tag, " err"},  obsOf(inst, F_ERR),  32'(expErr));
    checkOutput({tag, " ffv"},  obsOf(inst, F_FFV),  32'(seenFail));
    checkOutput({tag, " ffi"},  obsOf(inst, F_FFI),  32'(expFirst));
    checkOutput({tag, " last stim"}, obsOf(inst, F_STIM), 32'(stopK));
  endtask

  task automatic runSweep(input int inst, input string tag, input logic [15:0] resp);
    setResp(inst, resp);
    applyStimulus(inst, 1'b0);
    followSweep(inst, tag, resp);
  endtask

  // Directed sequence with randomised cell responses mixed in.
  initial begin
    logic [15:0] r;
    RN       = 1'b1;
    startVec = 3'b000;
    respA    = 8'h7F;
    respB    = 8'h7F;
    respC    = 16'h7FFF;
    #1 RN = 1'b0;
    #1;
    checkAllReset(0, "resetA");
    checkAllReset(1, "resetB");
    checkAllReset(2, "resetC");
    @(negedge CK);
    RN = 1'b1;

    runSweep(0, "nand3", 16'h007F);
    runSweep(0, "tied1", 16'h00FF);
    runSweep(0, "tied0", 16'h0000);
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom) & 16'h00FF;
      runSweep(0, $sformatf("randA%0d", i), r);
    end

    runSweep(1, "stopTied0", 16'h0000);
    runSweep(1, "stopClean", 16'h007F);
    runSweep(1, "stopLast",  16'h00FF);
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom) & 16'h00FF;
      runSweep(1, $sformatf("randB%0d", i), r);
    end

    // Abort mid-sweep with RN while pattern 4 is on the cell.
    setResp(0, 16'h007F);
    applyStimulus(0, 1'b0);
    repeat (8) @(negedge CK);
    checkOutput("abort pre stim", obsOf(0, F_STIM), 4);
    RN = 1'b0;
    #1;
    checkAllReset(0, "abortA");
    @(negedge CK);
    RN = 1'b1;
    repeat (3) @(negedge CK);
    checkOutput("post-abort idle stim", obsOf(0, F_STIM), 0);
    checkOutput("post-abort idle busy", obsOf(0, F_BUSY), 0);
    runSweep(0, "afterAbort", 16'h007F);

    // Start re-raised at e0+5 and held: ignored mid-sweep, restarts from DONE.
    setResp(0, 16'h00FF);
    applyStimulus(0, 1'b0);
    repeat (4) @(negedge CK);
    startVec[0] = 1'b1;
    repeat (12) @(negedge CK);
    checkOutput("restart first done", obsOf(0, F_DONE), 1);
    checkOutput("restart first err",  obsOf(0, F_ERR),  1);
    checkOutput("restart first stim", obsOf(0, F_STIM), 7);
    @(negedge CK);
    checkOutput("restart busy", obsOf(0, F_BUSY), 1);
    checkOutput("restart done", obsOf(0, F_DONE), 0);
    checkOutput("restart err",  obsOf(0, F_ERR),  0);
    checkOutput("restart ffv",  obsOf(0, F_FFV),  0);
    startVec[0] = 1'b0;
    followSweep(0, "restart2", 16'h00FF);

    runSweep(2, "nand4", 16'h7FFF);
    repeat (2) begin
      @(negedge CK);
      checkOutput("nand4 no wrap stim", obsOf(2, F_STIM), 15);
      checkOutput("nand4 hold done",    obsOf(2, F_DONE), 1);
    end
    for (int i = 0; i < 2; i++) begin
      r = 16'($urandom);
      runSweep(2, $sformatf("randC%0d", i), r);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
